// File: rtl/calc_cmd_scheduler.sv
// Keypad-to-calculator command scheduler: key FIFO, status handshake FSM,
// display digit capture, and error/timeout recovery with a core reset pulse.
module calc_cmd_scheduler #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMEOUT    = 1024,
    parameter logic [3:0]  IDLE_CMD   = 4'hD
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [3:0]                    key_code,
    output logic                          key_ready,
    input  logic                          clear,
    input  logic [1:0]                    calc_status,
    input  logic [3:0]                    calc_data,
    input  logic [3:0]                    calc_pos,
    output logic [3:0]                    calc_cmd,
    output logic                          calc_rst,
    output logic [31:0]                   disp,
    output logic                          disp_valid,
    output logic                          err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_READY,
        S_GAP,
        S_ERROR
    } state_t;

    state_t          state;
    logic [3:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [3:0]      shadow [8];
    logic [31:0]     shadow_flat;
    logic [TW-1:0]   timer;
    logic            push;
    logic            pop;
    logic            timer_expired;

    assign key_ready     = (count < CW'(FIFO_DEPTH)) && (state != S_ERROR);
    assign fifo_count    = count;
    assign push          = key_valid && key_ready && !clear;
    assign pop           = (state == S_IDLE) && (count != '0) && (calc_status == ST_READY) && !clear;
    assign timer_expired = (timer == TW'(TIMEOUT - 1));

    always_comb begin
        shadow_flat = '0;
        for (int i = 0; i < 8; i++)
            shadow_flat[i*4 +: 4] = shadow[i];
    end

    // NOTE: FIFO storage is deliberately not reset; count and pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr] <= key_code;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset || clear || state == S_ERROR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state      <= S_IDLE;
            calc_cmd   <= IDLE_CMD;
            calc_rst   <= clear && !reset;
            disp       <= '0;
            disp_valid <= 1'b0;
            err        <= 1'b0;
            timer      <= '0;
            for (int i = 0; i < 8; i++)
                shadow[i] <= '0;
        end else begin
            calc_rst   <= 1'b0;
            disp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    calc_cmd <= IDLE_CMD;
                    if (pop) begin
                        calc_cmd <= fifo_mem[rd_ptr];
                        timer    <= '0;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (calc_status == ST_ERR || (calc_status != ST_BUSY && timer_expired)) begin
                        err      <= 1'b1;
                        calc_cmd <= IDLE_CMD;
                        state    <= S_ERROR;
                    end else if (calc_status == ST_BUSY) begin
                        timer <= '0;
                        state <= S_WAIT_READY;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WAIT_READY: begin
                    if (calc_status == ST_ERR || (calc_status != ST_READY && timer_expired)) begin
                        err      <= 1'b1;
                        calc_cmd <= IDLE_CMD;
                        state    <= S_ERROR;
                    end else if (calc_status == ST_READY) begin
                        disp       <= shadow_flat;
                        disp_valid <= 1'b1;
                        calc_cmd   <= IDLE_CMD;
                        state      <= S_GAP;
                    end else begin
                        if (calc_status == ST_BUSY && !calc_pos[3])
                            shadow[calc_pos[2:0]] <= calc_data;
                        timer <= timer + TW'(1);
                    end
                end
                S_GAP: begin
                    calc_cmd <= IDLE_CMD;
                    state    <= S_IDLE;
                end
                S_ERROR: begin
                    err      <= 1'b1;
                    calc_cmd <= IDLE_CMD;
                end
                default: begin
                    calc_cmd <= IDLE_CMD;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
